// File: rtl/router_out_demux.sv
// router_out_demux: buffers wormhole flits in a small FIFO, latches the route
// decision when a head flit reaches the FIFO head, and steers the rest of the
// packet to the LOCAL, XDIR or YDIR output port until the tail leaves.
module router_out_demux #(
    parameter int FLIT_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FLIT_W-1:0] in_flit,
    input  logic              in_head,
    input  logic              in_tail,
    input  logic              to_demux,
    input  logic              dx,
    input  logic              dy,
    output logic [FLIT_W-1:0] out_flit,
    output logic              out_tail,
    output logic              out_local_valid,
    input  logic              out_local_ready,
    output logic              out_x_valid,
    input  logic              out_x_ready,
    output logic              out_y_valid,
    input  logic              out_y_ready,
    output logic              busy,
    output logic              err_drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_LOCAL,
        SEL_X,
        SEL_Y
    } sel_t;

    // Each entry holds {head, tail, payload}.
    logic [FLIT_W+1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    state_t            state;
    sel_t              sel;

    logic not_empty;
    logic head_is_head;
    logic sel_ready;
    logic push;
    logic pop;

    // dy only matters to the later hop; when dx=0 the Y port is chosen
    // regardless, so it is carried here without affecting steering.
    logic route_unused;
    assign route_unused = dy;

    assign not_empty    = (count != '0);
    assign head_is_head = mem[rd_ptr][FLIT_W+1];
    assign in_ready     = !rst && (count < FULL_COUNT);
    assign push         = in_valid && in_ready;

    // Ready of whichever port the current packet is locked to.
    always_comb begin
        sel_ready = 1'b0;
        case (sel)
            SEL_LOCAL: sel_ready = out_local_ready;
            SEL_X:     sel_ready = out_x_ready;
            SEL_Y:     sel_ready = out_y_ready;
            default:   sel_ready = 1'b0;
        endcase
    end

    // A stray body flit in IDLE is discarded; in LOCKED the selected port drains.
    assign pop = not_empty &&
                 (((state == IDLE) && !head_is_head) ||
                  ((state == LOCKED) && sel_ready));

    // FIFO storage is not reset; stale contents are never visible once count is 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_head, in_tail, in_flit};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Route decision is taken in IDLE while a head waits; the port stays
    // locked until the tail entry is popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel   <= SEL_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (not_empty && head_is_head) begin
                        state <= LOCKED;
                        sel   <= !to_demux ? SEL_LOCAL : (dx ? SEL_X : SEL_Y);
                    end
                end
                LOCKED: begin
                    if (pop && out_tail) begin
                        state <= IDLE;
                        sel   <= SEL_NONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    sel   <= SEL_NONE;
                end
            endcase
        end
    end

    // Outputs are pure decodes of registered state, so they hold until accepted.
    assign out_flit        = mem[rd_ptr][FLIT_W-1:0];
    assign out_tail        = mem[rd_ptr][FLIT_W];
    assign out_local_valid = (state == LOCKED) && not_empty && (sel == SEL_LOCAL);
    assign out_x_valid     = (state == LOCKED) && not_empty && (sel == SEL_X);
    assign out_y_valid     = (state == LOCKED) && not_empty && (sel == SEL_Y);
    assign busy            = (state == LOCKED);
    assign err_drop        = (state == IDLE) && not_empty && !head_is_head;

endmodule
